// File: rtl/gpu_pkg.sv
// Shared GPU definitions: default widths and the sprite loader state encoding.
package gpu_pkg;

  localparam int unsigned ADD_WIDTH_DEF = 16;
  localparam int unsigned PIX_WIDTH_DEF = 12;
  localparam int unsigned LEN_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/sprite_loader.sv
// Sprite RAM write-side loader: turns a (base, length) command plus a pixel stream into
// pixel_arbiter write strobes. SPRITE_LOADER_BLANK_ONLY_EN gates the stream to blanking.
module sprite_loader
  import gpu_pkg::*;
#(
  parameter int unsigned ADD_WIDTH = ADD_WIDTH_DEF,
  parameter int unsigned PIX_WIDTH = PIX_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADD_WIDTH-1:0] base_add,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic [PIX_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 blank,
  output logic [ADD_WIDTH-1:0] wr_add,
  output logic [PIX_WIDTH-1:0] wr_data,
  output logic                 wr_req,
  output logic                 busy,
  output logic                 done
);

  loader_state_t        r_state;
  loader_state_t        w_state_nxt;

  logic [ADD_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0] r_last_idx;
  logic [LEN_WIDTH-1:0] r_count;
  logic [ADD_WIDTH-1:0] r_wr_add;
  logic [PIX_WIDTH-1:0] r_wr_data;
  logic                 r_wr_req;

  logic                 w_gate;
  logic                 w_s_ready;
  logic                 w_xfer;
  logic                 w_last;
  logic                 w_accept;

`ifdef SPRITE_LOADER_BLANK_ONLY_EN
  // Stream only during blanking so writes never contend with display reads.
  assign w_gate = blank;
`else
  logic w_unused_blank;
  assign w_unused_blank = blank;
  assign w_gate         = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_xfer      = 1'b0;
    w_last      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            w_state_nxt = DONE;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        w_s_ready = w_gate;
        w_xfer    = w_gate & s_valid;
        w_last    = (r_count == r_last_idx);
        if (w_xfer && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Command latch, pixel counter and write port registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_base     <= '0;
      r_last_idx <= '0;
      r_count    <= '0;
      r_wr_add   <= '0;
      r_wr_data  <= '0;
      r_wr_req   <= 1'b0;
    end else begin
      r_wr_req <= w_xfer;
      if (w_accept) begin
        r_base     <= base_add;
        r_last_idx <= LEN_WIDTH'(length - LEN_WIDTH'(1));
        r_count    <= '0;
      end
      // Address wraps modulo 2^ADD_WIDTH; wr_add/wr_data hold between writes.
      if (w_xfer) begin
        r_wr_add  <= ADD_WIDTH'(r_base + ADD_WIDTH'(r_count));
        r_wr_data <= s_data;
        r_count   <= LEN_WIDTH'(r_count + LEN_WIDTH'(1));
      end
    end
  end

  assign s_ready = w_s_ready;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign wr_add  = r_wr_add;
  assign wr_data = r_wr_data;
  assign wr_req  = r_wr_req;

endmodule
